// File: rtl/wb_queue.sv
// Writeback queue feeding the register-file write port.
// In-order result buffer with decode hazard lookup and forwarding.
module wb_queue #(
   parameter int DEPTH    = 4,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 14
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ADDR_W-1:0]       in_rd,
   input  logic [DATA_W-1:0]       in_data,
   input  logic                    in_ucode,
   input  logic                    drain_en,
   output logic [ADDR_W-1:0]       rd,
   output logic                    write,
   output logic [DATA_W-1:0]       writeData,
   output logic                    uCodeFlag,
   input  logic [ADDR_W-1:0]       q_rs1,
   input  logic [ADDR_W-1:0]       q_rs2,
   input  logic                    q_ucode,
   output logic                    hz_rs1,
   output logic                    hz_rs2,
   output logic [DATA_W-1:0]       fwd_rs1,
   output logic [DATA_W-1:0]       fwd_rs2,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

   logic [ADDR_W-1:0] m_rd   [DEPTH];
   logic [DATA_W-1:0] m_data [DEPTH];
   logic              m_uc   [DEPTH];

   logic [PW-1:0] wp;
   logic [PW-1:0] rp;
   logic [PW-1:0] idx;
   logic [CW-1:0] cnt;
   logic          push;
   logic          pop;

   assign in_ready = (cnt != CW'(DEPTH));
   assign count    = cnt;
   assign push     = in_valid && in_ready && !flush && (in_rd != ZR);
   assign pop      = drain_en && (cnt != '0) && !flush;

   always_ff @(posedge clk) begin
      if (push) begin
         m_rd[wp]   <= in_rd;
         m_data[wp] <= in_data;
         m_uc[wp]   <= in_ucode;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp        <= '0;
         rp        <= '0;
         cnt       <= '0;
         write     <= 1'b0;
         rd        <= '0;
         writeData <= '0;
         uCodeFlag <= 1'b0;
      end else if (flush) begin
         wp    <= '0;
         rp    <= '0;
         cnt   <= '0;
         write <= 1'b0;
      end else begin
         write <= pop;
         if (pop) begin
            rd        <= m_rd[rp];
            writeData <= m_data[rp];
            uCodeFlag <= m_uc[rp];
            rp        <= rp + 1'b1;
         end
         if (push)
            wp <= wp + 1'b1;
         unique case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Scan oldest to youngest so the last match is the youngest value.
   always_comb begin
      hz_rs1  = 1'b0;
      hz_rs2  = 1'b0;
      fwd_rs1 = '0;
      fwd_rs2 = '0;
      idx     = rp;
      if (write && uCodeFlag == q_ucode) begin
         if (rd == q_rs1) begin
            hz_rs1  = 1'b1;
            fwd_rs1 = writeData;
         end
         if (rd == q_rs2) begin
            hz_rs2  = 1'b1;
            fwd_rs2 = writeData;
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         idx = rp + PW'(i);
         if (CW'(i) < cnt && m_uc[idx] == q_ucode) begin
            if (m_rd[idx] == q_rs1) begin
               hz_rs1  = 1'b1;
               fwd_rs1 = m_data[idx];
            end
            if (m_rd[idx] == q_rs2) begin
               hz_rs2  = 1'b1;
               fwd_rs2 = m_data[idx];
            end
         end
      end
      if (q_rs1 == ZR) begin
         hz_rs1  = 1'b0;
         fwd_rs1 = '0;
      end
      if (q_rs2 == ZR) begin
         hz_rs2  = 1'b0;
         fwd_rs2 = '0;
      end
   end

endmodule
